// File: rtl/cb_input_collector.sv
// cb_input_collector: collects words arriving one per cycle into groups of 8
// for the commutator-buffer shift segment of the FFT datapath. Two ping-pong
// banks let the next group fill while the segment drains the current one.
// A flush closes a partial group and pads the unused slots with zeros.
module cb_input_collector #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_d0,
  output logic [DATA_WIDTH-1:0] out_d1,
  output logic [DATA_WIDTH-1:0] out_d2,
  output logic [DATA_WIDTH-1:0] out_d3,
  output logic [DATA_WIDTH-1:0] out_d4,
  output logic [DATA_WIDTH-1:0] out_d5,
  output logic [DATA_WIDTH-1:0] out_d6,
  output logic [DATA_WIDTH-1:0] out_d7,
  output logic [3:0]            out_count
);

  logic [DATA_WIDTH-1:0] r_bank [2][8];
  logic [1:0]            r_full;
  logic [3:0]            r_cnt [2];
  logic [2:0]            r_wr_cnt;
  logic                  r_wr_bank;
  logic                  r_rd_bank;

  logic                  w_wr;
  logic [3:0]            w_eff_cnt;
  logic                  w_close_full;
  logic                  w_close_flush;
  logic                  w_close;
  logic                  w_release;
  logic [1:0]            w_full_nxt;

  // in_ready depends only on registered state, never on out_ready/in_valid.
  assign in_ready      = ~r_full[r_wr_bank];
  assign w_wr          = in_valid & in_ready;
  assign w_eff_cnt     = {1'b0, r_wr_cnt} + {3'b000, w_wr};
  assign w_close_full  = w_wr && (r_wr_cnt == 3'd7);
  // A flush landing on the 8th write is redundant; the group closes as full.
  assign w_close_flush = flush && in_ready && !w_close_full && (w_eff_cnt != 4'd0);
  assign w_close       = w_close_full | w_close_flush;
  assign w_release     = r_full[r_rd_bank] & out_ready;

  // Next full flags: closing and release always hit different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_close)   w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
  end

  // Bank storage: write the incoming word, zero-pad the tail on a flush close.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 8; i++)
          r_bank[b][i] <= '0;
    end else begin
      if (w_wr) r_bank[r_wr_bank][r_wr_cnt] <= in_data;
      if (w_close_flush) begin
        for (int i = 0; i < 8; i++)
          if (4'(i) >= w_eff_cnt) r_bank[r_wr_bank][i] <= '0;
      end
    end
  end

  // Control state: fill pointer, bank pointers, full flags and group counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full    <= 2'b00;
      r_cnt[0]  <= 4'd0;
      r_cnt[1]  <= 4'd0;
      r_wr_cnt  <= 3'd0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_close) begin
        r_cnt[r_wr_bank] <= w_close_full ? 4'd8 : w_eff_cnt;
        r_wr_bank        <= ~r_wr_bank;
        r_wr_cnt         <= 3'd0;
      end else if (w_wr) begin
        r_wr_cnt <= r_wr_cnt + 3'd1;
      end
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  assign out_valid = r_full[r_rd_bank];
  assign out_count = r_cnt[r_rd_bank];
  assign out_d0    = r_bank[r_rd_bank][0];
  assign out_d1    = r_bank[r_rd_bank][1];
  assign out_d2    = r_bank[r_rd_bank][2];
  assign out_d3    = r_bank[r_rd_bank][3];
  assign out_d4    = r_bank[r_rd_bank][4];
  assign out_d5    = r_bank[r_rd_bank][5];
  assign out_d6    = r_bank[r_rd_bank][6];
  assign out_d7    = r_bank[r_rd_bank][7];

endmodule

// File: tb/tb_cb_input_collector.sv
// Testbench for cb_input_collector: a driver issues directed and random
// traffic and a group-level reference model pushes expected groups into a
// queue; an independent monitor compares what the DUT presents.
module tb_cb_input_collector;

  localparam int DW = 32;

  typedef struct packed {
    logic [3:0]         cnt;
    logic [7:0][DW-1:0] d;
  } grp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_d0, out_d1, out_d2, out_d3, out_d4, out_d5, out_d6, out_d7;
  logic [3:0]    out_count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] cur_q[$];
  grp_t          exp_q[$];
  int            pending = 0;

  cb_input_collector #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d0(out_d0), .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3),
    .out_d4(out_d4), .out_d5(out_d5), .out_d6(out_d6), .out_d7(out_d7),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic grp_t close_group();
    grp_t g;
    g.cnt = 4'(cur_q.size());
    for (int i = 0; i < 8; i++)
      g.d[i] = (i < cur_q.size()) ? cur_q[i] : '0;
    return g;
  endfunction

  // One cycle: apply inputs, let the edge happen, then advance the model.
  // Model: at most two closed-but-unreleased groups; input stalls at two.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic f,
                     input logic r, output logic acc);
    logic rel;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    #1;
    acc = v && (pending < 2);
    rel = r && (pending > 0);
    if (acc) cur_q.push_back(d);
    if (cur_q.size() == 8) begin
      exp_q.push_back(close_group());
      cur_q.delete();
      pending++;
    end else if (f && (pending < 2) && cur_q.size() > 0) begin
      exp_q.push_back(close_group());
      cur_q.delete();
      pending++;
    end
    if (rel) pending--;
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, r, acc);
  endtask

  task automatic stream(input logic [DW-1:0] first, input int n, input logic r);
    logic acc;
    int k = 0;
    int guard = 0;
    while (k < n && guard < 200) begin
      cyc(1'b1, first + DW'(k), 1'b0, r, acc);
      if (acc) k++;
      guard++;
    end
    chk("stream_budget", 264'(k), 264'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 264'(out_valid), 264'(0));
    chk({tag, "_out_count"}, 264'(out_count), 264'(0));
    chk({tag, "_in_ready"},  264'(in_ready),  264'(1));
    chk({tag, "_out_d"}, {8'h0, out_d7, out_d6, out_d5, out_d4, out_d3, out_d2, out_d1, out_d0}, 264'(0));
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset();
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst_async");
    cur_q.delete();
    exp_q.delete();
    pending = 0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  // Monitor: compare presented group with the scoreboard head, pop on release.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready", 264'(in_ready), 264'(pending < 2));
      chk("out_valid", 264'(out_valid), 264'(pending > 0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_group", 264'(1), 264'(0));
        end else begin
          chk("group", {out_count, out_d7, out_d6, out_d5, out_d4, out_d3, out_d2, out_d1, out_d0},
              264'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic acc;
    #3 check_reset_outputs("rst_init");
    @(posedge clk); #2;
    rst = 1'b1;

    // back-to-back group with consumer ready
    stream(32'd1, 8, 1'b1);
    idle(3, 1'b1);

    // backpressure: 16 accepted, stall, one release, resume
    stream(32'd1, 16, 1'b0);
    idle(3, 1'b0);
    cyc(1'b1, 32'd17, 1'b0, 1'b1, acc);
    stream(32'd17, 8, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // partial group closed by flush, then a new group from slot 0
    stream(32'hA, 3, 1'b1);
    idle(1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    idle(2, 1'b0);
    stream(32'h40, 8, 1'b1);
    idle(3, 1'b1);

    // flush on the 8th write: exactly one full group
    stream(32'h50, 7, 1'b1);
    cyc(1'b1, 32'h57, 1'b1, 1'b1, acc);
    idle(3, 1'b1);

    // flush with empty bank: nothing produced
    cyc(1'b0, '0, 1'b1, 1'b1, acc);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    idle(2, 1'b0);

    // reset after 5 words, then a clean group
    stream(32'h60, 5, 1'b0);
    async_reset();
    stream(32'h21, 8, 1'b1);
    idle(3, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)), acc);
    end
    idle(6, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1, acc);
    idle(4, 1'b1);
    chk("scoreboard_drained", 264'(exp_q.size()), 264'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
